// File: rtl/sm4_msg_framer.sv
// Message framer in front of the SM4 core: packs a 32-bit word stream into 128-bit blocks,
// applies PKCS#7 padding, buffers the message and replays it as one core frame.
module sm4_msg_framer #(
    parameter int unsigned DEPTH = 16,
    parameter bit          PAD   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    input  logic         in_dec,
    input  logic [127:0] in_key,
    output logic [127:0] core_datain,
    output logic [127:0] core_mkin,
    output logic         core_start,
    output logic         core_end,
    output logic         core_isdec,
    input  logic         core_valid,
    output logic         err,
    output logic         busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 8 + AW;
    localparam logic [AW:0]   DEPTH_C   = DEPTH[AW:0];
    localparam logic [AW:0]   ONE_C     = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] SIXTEEN_C = {{(CW-5){1'b0}}, 5'd16};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        PADF    = 3'd2,
        START   = 3'd3,
        BURST   = 3'd4,
        WAIT    = 3'd5,
        DROP    = 3'd6
    } state_t;

    state_t         state_r;
    logic [127:0]   blk_mem_r [DEPTH];
    logic [127:0]   acc_r;
    logic [CW-1:0]  cnt_r;
    logic [AW:0]    wr_r;
    logic [AW:0]    n_r;
    logic [AW:0]    k_r;
    logic [AW:0]    vcnt_r;
    logic           dec_r;
    logic [127:0]   key_r;

    logic           in_fire_s;
    logic [2:0]     eff_bytes_s;
    logic [127:0]   next_acc_s;
    logic           blk_done_s;
    logic           overflow_s;
    logic [3:0]     rem_s;
    logic           padf_err_s;
    logic [AW:0]    pad_n_s;
    logic           buf_we_s;
    logic [AW-1:0]  buf_wa_s;
    logic [127:0]   buf_wd_s;

    // Bytes at or beyond rem are overwritten with the pad value; rem=0 yields a full 0x10 block.
    function automatic logic [127:0] pad_block(input logic [127:0] blk, input logic [3:0] rem);
        logic [127:0] r;
        logic [7:0]   p;
        p = 8'd16 - {4'd0, rem};
        r = blk;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = (4'(i) < rem) ? blk[127-8*i -: 8] : p;
        end
        return r;
    endfunction

    // Handshake outputs are decoded from state and forced low during reset.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
            busy     = 1'b0;
        end else begin
            in_ready = (state_r == IDLE) || (state_r == COLLECT) || (state_r == DROP);
            busy     = (state_r != IDLE);
        end
    end

    // Word packing: a non-last word always carries 4 bytes, so words stay word-aligned in a block.
    always_comb begin
        in_fire_s = in_valid && in_ready;
        if (in_last && (in_bytes != 3'd0) && (in_bytes <= 3'd4)) begin
            eff_bytes_s = in_bytes;
        end else begin
            eff_bytes_s = 3'd4;
        end
        next_acc_s = acc_r;
        case (cnt_r[3:2])
            2'd0:    next_acc_s[127:96] = in_data;
            2'd1:    next_acc_s[95:64]  = in_data;
            2'd2:    next_acc_s[63:32]  = in_data;
            2'd3:    next_acc_s[31:0]   = in_data;
            default: next_acc_s         = acc_r;
        endcase
        blk_done_s = (cnt_r[3:2] == 2'd3) && (eff_bytes_s == 3'd4);
        overflow_s = (state_r == COLLECT) && (wr_r == DEPTH_C);
    end

    // Frame validation and block count resolved in PADF.
    always_comb begin
        rem_s = cnt_r[3:0];
        if (dec_r) begin
            padf_err_s = (cnt_r != SIXTEEN_C);
        end else if (PAD) begin
            padf_err_s = (wr_r == DEPTH_C);
        end else begin
            padf_err_s = (rem_s != 4'd0) || (cnt_r == '0);
        end
        if (!dec_r && PAD) begin
            pad_n_s = wr_r + ONE_C;
        end else begin
            pad_n_s = wr_r;
        end
    end

    // Buffer write port: completed data blocks while collecting, the pad block in PADF.
    always_comb begin
        buf_wa_s = wr_r[AW-1:0];
        if (state_r == PADF) begin
            buf_we_s = !rst && !padf_err_s && PAD && !dec_r;
            buf_wd_s = pad_block(acc_r, rem_s);
        end else begin
            buf_we_s = !rst && ((state_r == IDLE) || (state_r == COLLECT)) &&
                       in_fire_s && !overflow_s && blk_done_s;
            buf_wd_s = next_acc_s;
        end
    end

    // Block storage holds no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            blk_mem_r[buf_wa_s] <= buf_wd_s;
        end
    end

    // Control FSM; core-facing outputs are registered one state ahead of the cycle they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            wr_r        <= '0;
            n_r         <= '0;
            k_r         <= '0;
            vcnt_r      <= '0;
            dec_r       <= 1'b0;
            key_r       <= '0;
            core_datain <= '0;
            core_mkin   <= '0;
            core_start  <= 1'b0;
            core_end    <= 1'b0;
            core_isdec  <= 1'b0;
            err         <= 1'b0;
        end else begin
            core_datain <= '0;
            core_start  <= 1'b0;
            core_end    <= 1'b0;
            core_isdec  <= 1'b0;
            err         <= 1'b0;
            case (state_r)
                IDLE, COLLECT: begin
                    if (in_fire_s) begin
                        if (state_r == IDLE) begin
                            dec_r <= in_dec;
                            key_r <= in_key;
                        end
                        if (overflow_s) begin
                            err     <= 1'b1;
                            cnt_r   <= '0;
                            wr_r    <= '0;
                            state_r <= in_last ? IDLE : DROP;
                        end else begin
                            acc_r   <= next_acc_s;
                            cnt_r   <= cnt_r + {{(CW-3){1'b0}}, eff_bytes_s};
                            if (blk_done_s) begin
                                wr_r <= wr_r + ONE_C;
                            end
                            state_r <= in_last ? PADF : COLLECT;
                        end
                    end
                end
                PADF: begin
                    if (padf_err_s) begin
                        err     <= 1'b1;
                        cnt_r   <= '0;
                        wr_r    <= '0;
                        state_r <= IDLE;
                    end else begin
                        n_r        <= pad_n_s;
                        core_start <= 1'b1;
                        core_mkin  <= key_r;
                        state_r    <= START;
                    end
                end
                START: begin
                    core_datain <= blk_mem_r[0];
                    core_end    <= (n_r == ONE_C);
                    core_isdec  <= dec_r;
                    k_r         <= ONE_C;
                    state_r     <= BURST;
                end
                BURST: begin
                    if (k_r == n_r) begin
                        state_r <= WAIT;
                    end else begin
                        core_datain <= blk_mem_r[k_r[AW-1:0]];
                        core_end    <= ((k_r + ONE_C) == n_r);
                        core_isdec  <= dec_r;
                        k_r         <= k_r + ONE_C;
                    end
                end
                WAIT: begin
                    if (core_valid) begin
                        if ((vcnt_r + ONE_C) == n_r) begin
                            cnt_r     <= '0;
                            wr_r      <= '0;
                            n_r       <= '0;
                            k_r       <= '0;
                            vcnt_r    <= '0;
                            core_mkin <= '0;
                            state_r   <= IDLE;
                        end else begin
                            vcnt_r <= vcnt_r + ONE_C;
                        end
                    end
                end
                DROP: begin
                    if (in_fire_s && in_last) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_msg_framer.sv
// Self-checking bench for sm4_msg_framer: directed vector table, randomized messages against a
// byte-level PKCS#7 reference model, plus back-pressure, overflow and mid-frame reset sequences.
module tb_sm4_msg_framer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [2:0]   in_bytes = 3'd0;
    logic         in_dec = 1'b0;
    logic [127:0] in_key = '0;
    logic         core_valid = 1'b0;
    logic         use2 = 1'b0;

    logic         in_ready, core_start, core_end, core_isdec, err, busy;
    logic [127:0] core_datain, core_mkin;
    logic         in_ready2, core_start2, core_end2, core_isdec2, err2, busy2;
    logic [127:0] core_datain2, core_mkin2;
    logic         v_main, v_d2, rdy_s;

    assign v_main = in_valid & ~use2;
    assign v_d2   = in_valid & use2;
    assign rdy_s  = use2 ? in_ready2 : in_ready;

    always #5 clk = ~clk;

    sm4_msg_framer #(.DEPTH(16), .PAD(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v_main), .in_ready(in_ready),
        .in_last(in_last), .in_bytes(in_bytes), .in_dec(in_dec), .in_key(in_key),
        .core_datain(core_datain), .core_mkin(core_mkin), .core_start(core_start),
        .core_end(core_end), .core_isdec(core_isdec), .core_valid(core_valid & ~use2),
        .err(err), .busy(busy)
    );

    sm4_msg_framer #(.DEPTH(2), .PAD(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v_d2), .in_ready(in_ready2),
        .in_last(in_last), .in_bytes(in_bytes), .in_dec(in_dec), .in_key(in_key),
        .core_datain(core_datain2), .core_mkin(core_mkin2), .core_start(core_start2),
        .core_end(core_end2), .core_isdec(core_isdec2), .core_valid(core_valid & use2),
        .err(err2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   msg_q[$];
    bit           msg_dec;
    logic [127:0] msg_key;
    logic [127:0] exp_q[$];
    bit           exp_err;

    typedef struct {
        int           len;
        logic [7:0]   base;
        bit           dec;
        logic [127:0] key;
        bit           err;
        int           n;
        logic [127:0] b0;
        logic [127:0] bl;
        bit           bp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pad the byte string, cut it into 16-byte blocks, reject what cannot fit.
    task automatic model();
        logic [7:0]   padded[$];
        logic [127:0] blk;
        int           p;
        exp_q.delete();
        padded = msg_q;
        if (msg_dec) begin
            exp_err = (msg_q.size() != 16);
        end else begin
            p = 16 - (msg_q.size() % 16);
            repeat (p) padded.push_back(8'(p));
            exp_err = ((padded.size() / 16) > 16);
        end
        if (!exp_err) begin
            for (int b = 0; b < padded.size() / 16; b++) begin
                blk = '0;
                for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = padded[16*b+j];
                exp_q.push_back(blk);
            end
        end
    endtask

    task automatic send_words();
        int len;
        int nw;
        int nb;
        int guard;
        logic [31:0] wd;
        len = msg_q.size();
        nw  = (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            nb = ((len - 4*w) >= 4) ? 4 : (len - 4*w);
            for (int j = 0; j < 4; j++) begin
                wd[31-8*j -: 8] = (j < nb) ? msg_q[4*w+j] : 8'($urandom);
            end
            in_data = wd;
            in_last = (w == nw - 1);
            if (w == nw - 1) begin
                in_bytes = (nb == 4) ? (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4) : 3'(nb);
            end else begin
                in_bytes = 3'($urandom);
            end
            in_dec   = (w == 0) ? msg_dec : 1'($urandom);
            in_key   = (w == 0) ? msg_key : {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            guard = 0;
            while ((rdy_s !== 1'b1) && (guard < 200)) begin
                step();
                guard++;
            end
            chk1("ready_wait", (guard < 200), 1'b1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Entered one sample after the last word was accepted (PADF cycle).
    task automatic check_frame(input bit bp);
        int n;
        int gaps;
        n = exp_q.size();
        chk1("padf_busy", busy, 1'b1);
        chk1("padf_ready", in_ready, 1'b0);
        chk1("padf_start", core_start, 1'b0);
        chk1("padf_err", err, 1'b0);
        if (bp) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = $urandom;
        end
        step();
        if (exp_err) begin
            chk1("err_pulse", err, 1'b1);
            chk1("err_nostart", core_start, 1'b0);
            chk1("err_idle", busy, 1'b0);
            chk1("err_ready", in_ready, 1'b1);
            in_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                step();
                chk1("err_once", err, 1'b0);
                chk1("err_nostart2", core_start, 1'b0);
            end
        end else begin
            chk1("start", core_start, 1'b1);
            chk("start_data", core_datain, 128'd0);
            chk1("start_end", core_end, 1'b0);
            chk1("start_ready", in_ready, 1'b0);
            core_valid = bp;
            step();
            for (int k = 0; k < n; k++) begin
                chk("blk_data", core_datain, exp_q[k]);
                chk1("blk_end", core_end, (k == n - 1));
                chk1("blk_isdec", core_isdec, msg_dec);
                chk("blk_mkin", core_mkin, msg_key);
                chk1("blk_nostart", core_start, 1'b0);
                chk1("blk_ready", in_ready, 1'b0);
                chk1("blk_err", err, 1'b0);
                step();
            end
            core_valid = 1'b0;
            chk1("wait_end", core_end, 1'b0);
            chk("wait_data", core_datain, 128'd0);
            chk1("wait_busy", busy, 1'b1);
            chk1("wait_ready", in_ready, 1'b0);
            for (int v = 0; v < n; v++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    step();
                    chk1("gap_busy", busy, 1'b1);
                end
                core_valid = 1'b1;
                step();
                core_valid = 1'b0;
                if (v == n - 1) begin
                    chk1("done_idle", busy, 1'b0);
                    chk1("done_ready", in_ready, 1'b1);
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end else begin
                    chk1("valid_wait", busy, 1'b1);
                    chk1("valid_ready", in_ready, 1'b0);
                end
            end
        end
    endtask

    task automatic apply_vec(input int i);
        msg_q.delete();
        for (int b = 0; b < vecs[i].len; b++) msg_q.push_back(vecs[i].base + 8'(b));
        msg_dec = vecs[i].dec;
        msg_key = vecs[i].key;
        exp_err = vecs[i].err;
        exp_q.delete();
        if (!vecs[i].err) exp_q.push_back(vecs[i].b0);
        if (!vecs[i].err && (vecs[i].n == 2)) exp_q.push_back(vecs[i].bl);
        send_words();
        check_frame(vecs[i].bp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        vecs[0] = '{len: 3, base: 8'h61, dec: 1'b0, key: 128'h11112222333344445555666677778888,
                    err: 1'b0, n: 1, b0: 128'h6162630D0D0D0D0D0D0D0D0D0D0D0D0D, bl: 128'd0, bp: 1'b0};
        vecs[1] = '{len: 16, base: 8'h00, dec: 1'b0, key: 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5,
                    err: 1'b0, n: 2, b0: 128'h000102030405060708090A0B0C0D0E0F,
                    bl: 128'h10101010101010101010101010101010, bp: 1'b1};
        vecs[2] = '{len: 16, base: 8'h20, dec: 1'b1, key: 128'h0123456789ABCDEFFEDCBA9876543210,
                    err: 1'b0, n: 1, b0: 128'h202122232425262728292A2B2C2D2E2F, bl: 128'd0, bp: 1'b0};
        vecs[3] = '{len: 20, base: 8'h20, dec: 1'b1, key: 128'h0123456789ABCDEFFEDCBA9876543210,
                    err: 1'b1, n: 0, b0: 128'd0, bl: 128'd0, bp: 1'b0};
        vecs[4] = '{len: 15, base: 8'hA0, dec: 1'b0, key: 128'hFFFF0000FFFF0000FFFF0000FFFF0000,
                    err: 1'b0, n: 1, b0: 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAE01, bl: 128'd0, bp: 1'b1};
        vecs[5] = '{len: 17, base: 8'h40, dec: 1'b0, key: 128'h00000000000000000000000000000001,
                    err: 1'b0, n: 2, b0: 128'h404142434445464748494A4B4C4D4E4F,
                    bl: 128'h500F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, bp: 1'b0};

        // Reset behaviour
        rst = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk1("rst_ready", in_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_start", core_start, 1'b0);
        chk1("rst_end", core_end, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_data", core_datain, 128'd0);
        chk("rst_mkin", core_mkin, 128'd0);
        rst = 1'b0;
        #1;
        chk1("post_rst_ready", in_ready, 1'b1);
        chk1("post_rst_busy", busy, 1'b0);

        // Directed vector table
        for (int i = 0; i < 6; i++) apply_vec(i);

        // Randomized messages against the reference model
        for (int r = 0; r < 40; r++) begin
            msg_dec = ($urandom_range(0, 3) == 0);
            if (msg_dec) begin
                len = ($urandom_range(0, 1) == 0) ? 16 : $urandom_range(1, 40);
            end else begin
                len = ($urandom_range(0, 9) == 0) ? 256 : $urandom_range(1, 255);
            end
            msg_q.delete();
            for (int b = 0; b < len; b++) msg_q.push_back(8'($urandom));
            msg_key = {$urandom, $urandom, $urandom, $urandom};
            model();
            send_words();
            check_frame(1'($urandom_range(0, 1)));
        end

        // Reset on the second BURST cycle of a 3-block frame
        msg_q.delete();
        for (int b = 0; b < 40; b++) msg_q.push_back(8'($urandom));
        msg_dec = 1'b0;
        msg_key = {$urandom, $urandom, $urandom, $urandom};
        model();
        send_words();
        step();
        chk1("rs_start", core_start, 1'b1);
        step();
        chk("rs_blk0", core_datain, exp_q[0]);
        step();
        chk("rs_blk1", core_datain, exp_q[1]);
        rst = 1'b1;
        step();
        chk("rs_data", core_datain, 128'd0);
        chk("rs_mkin", core_mkin, 128'd0);
        chk1("rs_end", core_end, 1'b0);
        chk1("rs_isdec", core_isdec, 1'b0);
        chk1("rs_err", err, 1'b0);
        chk1("rs_busy", busy, 1'b0);
        chk1("rs_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rs_ready_after", in_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk1("rs_no_end", core_end, 1'b0);
            chk1("rs_no_err", err, 1'b0);
        end
        apply_vec(0);

        // DEPTH=2: pad block needs a third slot
        use2 = 1'b1;
        msg_q.delete();
        for (int b = 0; b < 32; b++) msg_q.push_back(8'($urandom));
        msg_dec = 1'b0;
        msg_key = {$urandom, $urandom, $urandom, $urandom};
        send_words();
        chk1("d2_padf_busy", busy2, 1'b1);
        step();
        chk1("d2_pad_err", err2, 1'b1);
        chk1("d2_pad_nostart", core_start2, 1'b0);
        chk1("d2_pad_idle", busy2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk1("d2_pad_nostart2", core_start2, 1'b0);
            chk1("d2_pad_err_once", err2, 1'b0);
        end

        // DEPTH=2: 40-byte message overflows on word 9 and is drained until in_last
        for (int w = 0; w < 10; w++) begin
            in_data  = $urandom;
            in_last  = (w == 9);
            in_bytes = 3'd4;
            in_dec   = 1'b0;
            in_key   = msg_key;
            in_valid = 1'b1;
            chk1("d2_drop_ready", in_ready2, 1'b1);
            step();
            chk1("d2_drop_err", err2, (w == 8));
            chk1("d2_drop_busy", busy2, (w != 9));
            chk1("d2_drop_nostart", core_start2, 1'b0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        chk1("d2_drop_done_err", err2, 1'b0);
        chk1("d2_drop_done_ready", in_ready2, 1'b1);
        use2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
